// File: rtl/cdc_2phase_src_buffered_sync.sv
// Multi-flop synchroniser for a single asynchronous level, reset to 0.
// Used on the toggle acknowledge coming back from the destination domain.
module sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic serial_i,
   output logic serial_o
);

   logic [STAGES-1:0] sync_r;

   // shift the asynchronous level through the synchroniser chain
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_r <= {STAGES{1'b0}};
      end else begin
         sync_r <= {sync_r[STAGES-2:0], serial_i};
      end
   end

   assign serial_o = sync_r[STAGES-1];

endmodule

// File: rtl/cdc_2phase_src_buffered.sv
// Source half of a two-phase toggle req/ack crossing with a DEPTH-entry input buffer.
// A word accepted on one edge can launch on the next edge at the earliest.
module cdc_2phase_src_buffered #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         clear_i,
   input  logic [DATA_WIDTH-1:0]        data_i,
   input  logic                         valid_i,
   output logic                         ready_o,
   output logic [$clog2(DEPTH+1)-1:0]   level_o,
   output logic                         idle_o,
   output logic                         async_req_o,
   input  logic                         async_ack_i,
   output logic [DATA_WIDTH-1:0]        async_data_o
);

   localparam int unsigned       CNT_W    = $clog2(DEPTH + 1);
   localparam int unsigned       PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_r, wr_ptr_s;
   logic [PTR_W-1:0]      rd_ptr_r, rd_ptr_s;
   logic [CNT_W-1:0]      count_r, count_s;
   logic                  req_r, req_s;
   logic [DATA_WIDTH-1:0] data_r, data_s;
   logic                  ack_synced_s;
   logic                  chan_free_s;
   logic                  push_s;
   logic                  launch_s;

   // Pointers wrap explicitly so DEPTH need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
      if (ptr == LAST_PTR) begin
         return {PTR_W{1'b0}};
      end else begin
         return ptr + PTR_W'(1);
      end
   endfunction

   sync #(
      .STAGES (SYNC_STAGES)
   ) i_ack_sync (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .serial_i (async_ack_i),
      .serial_o (ack_synced_s)
   );

   // handshake decisions and next-state for pointers, count, req and launch register
   always_comb begin
      chan_free_s = (req_r == ack_synced_s);
      ready_o     = (count_r != FULL_CNT) && !clear_i;
      push_s      = valid_i && ready_o;
      launch_s    = chan_free_s && (count_r != {CNT_W{1'b0}}) && !clear_i;
      wr_ptr_s    = wr_ptr_r;
      rd_ptr_s    = rd_ptr_r;
      count_s     = count_r;
      req_s       = req_r;
      data_s      = data_r;
      if (clear_i) begin
         wr_ptr_s = {PTR_W{1'b0}};
         rd_ptr_s = {PTR_W{1'b0}};
         count_s  = {CNT_W{1'b0}};
         req_s    = 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_s = ptr_inc(wr_ptr_r);
         end else begin
            wr_ptr_s = wr_ptr_r;
         end
         if (launch_s) begin
            rd_ptr_s = ptr_inc(rd_ptr_r);
            req_s    = ~req_r;
            data_s   = mem_r[rd_ptr_r];
         end else begin
            rd_ptr_s = rd_ptr_r;
         end
         case ({push_s, launch_s})
            2'b10:   count_s = count_r + CNT_W'(1);
            2'b01:   count_s = count_r - CNT_W'(1);
            default: count_s = count_r;
         endcase
      end
   end

   // buffer storage is pure datapath and carries no reset
   always_ff @(posedge clk_i) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= data_i;
      end
   end

   // control state and the flops that drive the crossing
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
         req_r    <= 1'b0;
         data_r   <= {DATA_WIDTH{1'b0}};
      end else begin
         wr_ptr_r <= wr_ptr_s;
         rd_ptr_r <= rd_ptr_s;
         count_r  <= count_s;
         req_r    <= req_s;
         data_r   <= data_s;
      end
   end

   assign level_o      = count_r;
   assign idle_o       = (count_r == {CNT_W{1'b0}}) && chan_free_s;
   assign async_req_o  = req_r;
   assign async_data_o = data_r;

endmodule

// File: tb/tb_cdc_2phase_src_buffered.sv
// Directed bench for cdc_2phase_src_buffered (DATA_WIDTH=32, DEPTH=4, SYNC_STAGES=2).
// The bench plays the destination by driving async_ack_i from its own knowledge of req.
module tb_cdc_2phase_src_buffered;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        clear_i;
   logic [31:0] data_i;
   logic        valid_i;
   logic        ready_o;
   logic [2:0]  level_o;
   logic        idle_o;
   logic        async_req_o;
   logic        async_ack_i;
   logic [31:0] async_data_o;

   int unsigned n_pass = 0;
   int unsigned n_total = 0;

   cdc_2phase_src_buffered #(
      .DATA_WIDTH  (32),
      .DEPTH       (4),
      .SYNC_STAGES (2)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .clear_i      (clear_i),
      .data_i       (data_i),
      .valid_i      (valid_i),
      .ready_o      (ready_o),
      .level_o      (level_o),
      .idle_o       (idle_o),
      .async_req_o  (async_req_o),
      .async_ack_i  (async_ack_i),
      .async_data_o (async_data_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // Acknowledge the outstanding request, then wait (bounded) for the next launch.
   task automatic ack_and_launch(input string tag, input logic [31:0] exp_data,
                                 input logic [2:0] exp_level);
      logic prev;
      bit   seen;
      prev        = async_req_o;
      async_ack_i = async_req_o;
      seen        = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         step();
         if (async_req_o != prev) seen = 1'b1;
      end
      chk({tag, "_launched"}, {31'd0, seen}, 32'd1);
      chk({tag, "_data"}, async_data_o, exp_data);
      chk({tag, "_level"}, {29'd0, level_o}, {29'd0, exp_level});
   endtask

   // Return ack to match req and let it pass the synchroniser.
   task automatic settle();
      async_ack_i = async_req_o;
      repeat (3) step();
   endtask

   initial begin
      logic [31:0] words [6];
      words[0] = 32'h0000_0011; words[1] = 32'h0000_0022; words[2] = 32'h0000_0033;
      words[3] = 32'h0000_0044; words[4] = 32'h0000_0055; words[5] = 32'h0000_0066;

      rst_ni = 1'b0; clear_i = 1'b0; data_i = 32'd0; valid_i = 1'b0; async_ack_i = 1'b0;
      #12;
      // 1: reset state, single word, ack latency
      chk("rst_ready", {31'd0, ready_o}, 32'd1);
      chk("rst_level", {29'd0, level_o}, 32'd0);
      chk("rst_req",   {31'd0, async_req_o}, 32'd0);
      chk("rst_data",  async_data_o, 32'd0);
      chk("rst_idle",  {31'd0, idle_o}, 32'd1);
      step();
      rst_ni = 1'b1;
      step();
      data_i = 32'h0000_00A5; valid_i = 1'b1;
      step();
      valid_i = 1'b0;
      chk("t1_no_bypass_req", {31'd0, async_req_o}, 32'd0);
      chk("t1_level1", {29'd0, level_o}, 32'd1);
      step();
      chk("t1_req", {31'd0, async_req_o}, 32'd1);
      chk("t1_data", async_data_o, 32'h0000_00A5);
      chk("t1_busy", {31'd0, idle_o}, 32'd0);
      async_ack_i = 1'b1;
      step();
      chk("t1_idle_sync1", {31'd0, idle_o}, 32'd0);
      step();
      chk("t1_idle_sync2", {31'd0, idle_o}, 32'd1);

      // 2: burst of 5 with ack held, 6th stalls, then ordered drain
      for (int i = 0; i < 5; i++) begin
         data_i = words[i]; valid_i = 1'b1;
         step();
      end
      data_i = words[5];
      chk("t2_full_ready", {31'd0, ready_o}, 32'd0);
      chk("t2_full_level", {29'd0, level_o}, 32'd4);
      chk("t2_first_data", async_data_o, words[0]);
      step();
      chk("t2_stall_level", {29'd0, level_o}, 32'd4);
      chk("t2_stall_data", async_data_o, words[0]);
      valid_i = 1'b0;
      ack_and_launch("t2_w2", words[1], 3'd3);
      ack_and_launch("t2_w3", words[2], 3'd2);
      ack_and_launch("t2_w4", words[3], 3'd1);
      ack_and_launch("t2_w5", words[4], 3'd0);
      settle();
      chk("t2_idle", {31'd0, idle_o}, 32'd1);

      // 3: count==1 with free channel plus simultaneous push
      data_i = 32'h0000_0333; valid_i = 1'b1;
      step();
      chk("t3_level_pre", {29'd0, level_o}, 32'd1);
      data_i = 32'h0000_0444;
      step();
      chk("t3_level_same", {29'd0, level_o}, 32'd1);
      chk("t3_req", {31'd0, async_req_o}, 32'd1);
      chk("t3_data", async_data_o, 32'h0000_0333);

      // 4: clear with 3 queued, req=1, ack=0
      data_i = 32'h0000_0555;
      step();
      data_i = 32'h0000_0666;
      step();
      chk("t4_level3", {29'd0, level_o}, 32'd3);
      clear_i = 1'b1; data_i = 32'h0000_0777;
      #1;
      chk("t4_ready_clear", {31'd0, ready_o}, 32'd0);
      step();
      clear_i = 1'b0; valid_i = 1'b0;
      chk("t4_level0", {29'd0, level_o}, 32'd0);
      chk("t4_req0", {31'd0, async_req_o}, 32'd0);
      chk("t4_data_kept", async_data_o, 32'h0000_0333);
      chk("t4_idle", {31'd0, idle_o}, 32'd1);
      data_i = 32'h0000_0888; valid_i = 1'b1;
      step();
      valid_i = 1'b0;
      step();
      chk("t4_relaunch_req", {31'd0, async_req_o}, 32'd1);
      chk("t4_relaunch_data", async_data_o, 32'h0000_0888);
      settle();

      // 5: clear with req=1 and ack=1: channel busy until ack returns to 0
      clear_i = 1'b1;
      step();
      clear_i = 1'b0;
      chk("t5_req0", {31'd0, async_req_o}, 32'd0);
      chk("t5_busy", {31'd0, idle_o}, 32'd0);
      data_i = 32'h0000_0999; valid_i = 1'b1;
      step();
      valid_i = 1'b0;
      repeat (3) step();
      chk("t5_held_req", {31'd0, async_req_o}, 32'd0);
      chk("t5_held_level", {29'd0, level_o}, 32'd1);
      ack_and_launch("t5_go", 32'h0000_0999, 3'd0);
      settle();

      // 6: reset mid-burst, then a clean restart
      for (int i = 0; i < 3; i++) begin
         data_i = 32'h0000_0A01 + 32'(i); valid_i = 1'b1;
         step();
      end
      valid_i = 1'b0;
      chk("t6_level2", {29'd0, level_o}, 32'd2);
      chk("t6_data", async_data_o, 32'h0000_0A01);
      rst_ni = 1'b0; async_ack_i = 1'b0;
      #1;
      chk("t6_rst_req", {31'd0, async_req_o}, 32'd0);
      chk("t6_rst_level", {29'd0, level_o}, 32'd0);
      chk("t6_rst_data", async_data_o, 32'd0);
      chk("t6_rst_ready", {31'd0, ready_o}, 32'd1);
      step();
      rst_ni = 1'b1;
      step();
      data_i = 32'h0000_0B01; valid_i = 1'b1;
      step();
      valid_i = 1'b0;
      step();
      chk("t6_resume_req", {31'd0, async_req_o}, 32'd1);
      chk("t6_resume_data", async_data_o, 32'h0000_0B01);
      chk("t6_resume_level", {29'd0, level_o}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
